cz_flag_unit: RTL and testbench
===============================

// Module: cz_flag_unit
// PURPOSE
// Architectural carry/zero flag register for the pipelined core; directly downstream of the EX-stage ALU and feeding alu_op_ctrl.
// Commits C/Z from ALU results at end of EX and load-zero from the MEM stage.
// Forwards the flags the current EX instruction must see to alu_op_ctrl (carry, zero).
// Raises a one-cycle interlock when a load-to-Z dependency cannot be forwarded.
// Counts condition-nullified instructions for performance debug.
// PARAMETERS
// WIDTH       16  datapath width of alu_result / mem_rdata
// LOAD_Z_FWD  1   1: forward MEM load-zero combinationally; 0: interlock via flag_stall
// CNT_W       16  width of the nullified-instruction counter
// PORTS
// clk           in   1      clock, all state on rising edge
// rst_n         in   1      asynchronous, active-low reset
// ex_valid      in   1      EX stage holds a real instruction
// ex_stall      in   1      EX (and upstream) frozen this cycle
// ex_flush      in   1      EX instruction squashed this cycle
// ex_nullified  in   1      alu_op_ctrl forced NOP (alu_op_out==2'b11)
// ex_wr_c       in   1      EX instruction class writes C
// ex_wr_z       in   1      EX instruction class writes Z
// ex_rtype      in   1      EX instruction is R-type (conditional-capable)
// ex_c_in       in   1      instruction condition bit C
// ex_z_in       in   1      instruction condition bit Z
// alu_carry     in   1      ALU carry-out
// alu_result    in   WIDTH  ALU result
// mem_valid     in   1      MEM stage holds a real instruction
// mem_load_z    in   1      MEM instruction is a load that sets Z
// mem_rdata     in   WIDTH  load data in MEM
// carry         out  1      flag value seen by EX instruction (to alu_op_ctrl)
// zero          out  1      flag value seen by EX instruction (to alu_op_ctrl)
// carry_q       out  1      committed architectural C
// zero_q        out  1      committed architectural Z
// flag_stall    out  1      request to hold EX/upstream one cycle
// null_count    out  CNT_W  saturating count of nullified EX instructions
// BEHAVIOUR
// - Reset (rst_n=0, async): carry_q=0, zero_q=0, null_count=0; takes effect immediately, mid-operation.
// - ex_commit = ex_valid & ~ex_stall & ~ex_flush & ~flag_stall & ~ex_nullified.
// - mem_commit = mem_valid & mem_load_z; MEM is never frozen by ex_stall.
// - Z write value = (alu_result == 0); load Z value = (mem_rdata == 0).
// - Clock edge, C: if ex_commit & ex_wr_c, carry_q <= alu_carry.
// - Clock edge, Z: if ex_commit & ex_wr_z, zero_q <= ALU zero; else if mem_commit, zero_q <= load zero.
// - Same-edge EX and MEM Z writes: EX wins (EX instruction is younger).
// - Forwarding: carry = carry_q.
// - LOAD_Z_FWD=1: zero = mem_commit ? load zero : zero_q; flag_stall = 0.
// - LOAD_Z_FWD=0: zero = zero_q.
// - LOAD_Z_FWD=0: flag_stall = mem_commit & ex_valid & ex_rtype & ex_z_in & ~ex_c_in & ~ex_flush.
// - LOAD_Z_FWD=0: flag_stall deasserts next cycle once the load has committed zero_q.
// - A stalled EX instruction re-evaluates the forwarded flags every cycle; no flag write until it advances.
// - null_count: +1 per cycle with ex_valid & ex_nullified & ~ex_stall & ~ex_flush & ~flag_stall.
// - null_count saturates at all-ones; no wrap.
// - Zero-cycle latency on carry/zero/flag_stall (combinational from state and inputs).
// - One-cycle latency on carry_q/zero_q.
// STRUCTURE
// - Shared core package: ALU_OP_NOP = 2'b11; condition encodings {c_in,z_in}: 00 none, 10 on-C, 01 on-Z.
// - Shared core package: WIDTH default.
// - Sub-module sat_counter #(CNT_W) (en, q), reusable for other perf counters.
// - All else flat: two flag flops, zero detectors, forward mux, stall logic.
// TESTING
// - Reset: rst_n low mid-run with carry_q=zero_q=1, null_count=5 -> all 0 at once, carry=zero=0.
// - ADD commit: ex_wr_c=ex_wr_z=1, alu_carry=1, alu_result=0 -> next cycle carry_q=1, zero_q=1.
// - Nullify/flush/stall: each blocks flag write.
// - Nullify: null_count +1 only for ex_nullified; stays 0xFFFF at saturation.
// - Load fwd (LOAD_Z_FWD=1): mem_load_z, mem_rdata=0, zero_q=0 -> zero=1 same cycle, zero_q=1 next.
// - Load interlock (LOAD_Z_FWD=0): load in MEM + EX R-type z_in=1,c_in=0 -> flag_stall=1 one cycle.
// - Load interlock, next cycle: zero=new Z, flag_stall=0.
// - Collision: EX writes Z from alu_result=5 while MEM load rdata=0 -> zero_q=0 (EX wins).

Source files
------------

// File: rtl/cz_flag_unit_pkg.sv
// Shared core definitions: ALU op and condition encodings, default datapath width.
package cz_flag_unit_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned COND_W    = 2;

   localparam logic [1:0] ALU_OP_NOP = 2'b11;

   // Condition field is {c_in, z_in}
   localparam logic [COND_W-1:0] COND_NONE = 2'b00;
   localparam logic [COND_W-1:0] COND_ON_C = 2'b10;
   localparam logic [COND_W-1:0] COND_ON_Z = 2'b01;

   function automatic logic cond_on_z(input logic c_in, input logic z_in);
      return {c_in, z_in} == COND_ON_Z;
   endfunction

endpackage

// File: rtl/cz_flag_unit_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en && (q != {CNT_W{1'b1}})) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cz_flag_unit.sv
// Architectural C/Z flag register with EX/MEM commit, flag forwarding to
// alu_op_ctrl, load-to-Z interlock and nullified-instruction counter.
module cz_flag_unit
   import cz_flag_unit_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned LOAD_Z_FWD = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_stall,
   input  logic             ex_flush,
   input  logic             ex_nullified,
   input  logic             ex_wr_c,
   input  logic             ex_wr_z,
   input  logic             ex_rtype,
   input  logic             ex_c_in,
   input  logic             ex_z_in,
   input  logic             alu_carry,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             mem_valid,
   input  logic             mem_load_z,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             carry,
   output logic             zero,
   output logic             carry_q,
   output logic             zero_q,
   output logic             flag_stall,
   output logic [CNT_W-1:0] null_count
);

   logic alu_zero;
   logic load_zero;
   logic mem_commit;
   logic ex_advance;
   logic ex_commit;
   logic null_en;

   assign alu_zero   = (alu_result == '0);
   assign load_zero  = (mem_rdata == '0);
   assign mem_commit = mem_valid & mem_load_z;

   // An EX instruction advances unless held, squashed or interlocked
   assign ex_advance = ex_valid & ~ex_stall & ~ex_flush & ~flag_stall;
   assign ex_commit  = ex_advance & ~ex_nullified;
   assign null_en    = ex_advance & ex_nullified;

   // Forward mux and load-to-Z interlock
   always_comb begin
      carry      = carry_q;
      zero       = zero_q;
      flag_stall = 1'b0;
      if (LOAD_Z_FWD != 0) begin
         if (mem_commit) begin
            zero = load_zero;
         end
      end else begin
         flag_stall = mem_commit & ex_valid & ex_rtype &
                      cond_on_z(ex_c_in, ex_z_in) & ~ex_flush;
      end
   end

   // EX writes win over a same-edge MEM load write: EX is the younger instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         if (ex_commit && ex_wr_c) begin
            carry_q <= alu_carry;
         end
         if (ex_commit && ex_wr_z) begin
            zero_q <= alu_zero;
         end else if (mem_commit) begin
            zero_q <= load_zero;
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_null_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (null_en),
      .q     (null_count)
   );

endmodule

// File: tb/tb_cz_flag_unit.sv
// Bench for cz_flag_unit: a forwarding instance (narrow counter) and an
// interlocking instance share stimulus; a spec-level model fills a scoreboard.
module tb_cz_flag_unit;

   localparam int unsigned W   = 16;
   localparam int unsigned CWA = 4;
   localparam int unsigned CWB = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ex_valid, ex_stall, ex_flush, ex_nullified;
   logic         ex_wr_c, ex_wr_z, ex_rtype, ex_c_in, ex_z_in, alu_carry;
   logic [W-1:0] alu_result, mem_rdata;
   logic         mem_valid, mem_load_z;

   logic           a_carry, a_zero, a_cq, a_zq, a_stall;
   logic [CWA-1:0] a_cnt;
   logic           b_carry, b_zero, b_cq, b_zq, b_stall;
   logic [CWB-1:0] b_cnt;

   typedef struct {
      logic           c_a;
      logic           z_a;
      logic [CWA-1:0] n_a;
      logic           c_b;
      logic           z_b;
      logic [CWB-1:0] n_b;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cz_flag_unit #(.WIDTH(W), .LOAD_Z_FWD(1), .CNT_W(CWA)) u_fwd (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
      .ex_flush(ex_flush), .ex_nullified(ex_nullified), .ex_wr_c(ex_wr_c),
      .ex_wr_z(ex_wr_z), .ex_rtype(ex_rtype), .ex_c_in(ex_c_in), .ex_z_in(ex_z_in),
      .alu_carry(alu_carry), .alu_result(alu_result), .mem_valid(mem_valid),
      .mem_load_z(mem_load_z), .mem_rdata(mem_rdata), .carry(a_carry), .zero(a_zero),
      .carry_q(a_cq), .zero_q(a_zq), .flag_stall(a_stall), .null_count(a_cnt));

   cz_flag_unit #(.WIDTH(W), .LOAD_Z_FWD(0), .CNT_W(CWB)) u_ilk (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
      .ex_flush(ex_flush), .ex_nullified(ex_nullified), .ex_wr_c(ex_wr_c),
      .ex_wr_z(ex_wr_z), .ex_rtype(ex_rtype), .ex_c_in(ex_c_in), .ex_z_in(ex_z_in),
      .alu_carry(alu_carry), .alu_result(alu_result), .mem_valid(mem_valid),
      .mem_load_z(mem_load_z), .mem_rdata(mem_rdata), .carry(b_carry), .zero(b_zero),
      .carry_q(b_cq), .zero_q(b_zq), .flag_stall(b_stall), .null_count(b_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_stall = 0; ex_flush = 0; ex_nullified = 0;
      ex_wr_c = 0; ex_wr_z = 0; ex_rtype = 0; ex_c_in = 0; ex_z_in = 0;
      alu_carry = 0; alu_result = '0; mem_valid = 0; mem_load_z = 0; mem_rdata = '0;
   endtask

   function automatic logic [CWA-1:0] inc_a(input logic [CWA-1:0] v);
      return (v == {CWA{1'b1}}) ? v : v + CWA'(1);
   endfunction

   function automatic logic [CWB-1:0] inc_b(input logic [CWB-1:0] v);
      return (v == {CWB{1'b1}}) ? v : v + CWB'(1);
   endfunction

   // Called at the negedge with inputs already driven: check combinational
   // outputs, push the expected post-edge state, then pop and compare it.
   task automatic step();
      logic mc, lz, az, fs_b, adv_a, adv_b;
      exp_t e;
      exp_t got;
      #1;
      mc   = mem_valid & mem_load_z;
      lz   = (mem_rdata == '0);
      az   = (alu_result == '0);
      fs_b = mc & ex_valid & ex_rtype & ex_z_in & ~ex_c_in & ~ex_flush;
      chk("fwd_carry", 32'(a_carry), 32'(m.c_a));
      chk("fwd_zero",  32'(a_zero),  32'(mc ? lz : m.z_a));
      chk("fwd_stall", 32'(a_stall), 32'(0));
      chk("ilk_carry", 32'(b_carry), 32'(m.c_b));
      chk("ilk_zero",  32'(b_zero),  32'(m.z_b));
      chk("ilk_stall", 32'(b_stall), 32'(fs_b));
      adv_a = ex_valid & ~ex_stall & ~ex_flush;
      adv_b = adv_a & ~fs_b;
      e = m;
      if (adv_a & ~ex_nullified & ex_wr_c) e.c_a = alu_carry;
      if (adv_a & ~ex_nullified & ex_wr_z) e.z_a = az; else if (mc) e.z_a = lz;
      if (adv_a & ex_nullified) e.n_a = inc_a(m.n_a);
      if (adv_b & ~ex_nullified & ex_wr_c) e.c_b = alu_carry;
      if (adv_b & ~ex_nullified & ex_wr_z) e.z_b = az; else if (mc) e.z_b = lz;
      if (adv_b & ex_nullified) e.n_b = inc_b(m.n_b);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         got = exp_q.pop_front();
         chk("fwd_carry_q", 32'(a_cq),  32'(got.c_a));
         chk("fwd_zero_q",  32'(a_zq),  32'(got.z_a));
         chk("fwd_count",   32'(a_cnt), 32'(got.n_a));
         chk("ilk_carry_q", 32'(b_cq),  32'(got.c_b));
         chk("ilk_zero_q",  32'(b_zq),  32'(got.z_b));
         chk("ilk_count",   32'(b_cnt), 32'(got.n_b));
         m = got;
      end
      @(negedge clk);
   endtask

   task automatic ex_op(input logic wc, input logic wz, input logic cy, input logic [W-1:0] r);
      idle_inputs();
      ex_valid = 1; ex_wr_c = wc; ex_wr_z = wz; alu_carry = cy; alu_result = r;
   endtask

   task automatic model_reset();
      m = '{c_a: 1'b0, z_a: 1'b0, n_a: '0, c_b: 1'b0, z_b: 1'b0, n_b: '0};
      exp_q.delete();
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst_n = 0;
      #12;
      chk("rst_carry_q", 32'({a_cq, b_cq}), 32'(0));
      chk("rst_zero_q",  32'({a_zq, b_zq}), 32'(0));
      chk("rst_count",   32'(b_cnt), 32'(0));
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // ADD with carry-out and zero result
      ex_op(1, 1, 1, 16'h0000); step();
      chk("add_carry_q", 32'({a_cq, b_cq}), 32'(2'b11));
      chk("add_zero_q",  32'({a_zq, b_zq}), 32'(2'b11));

      // Nullified, stalled and flushed writes must not change the flags
      ex_op(1, 1, 0, 16'h0005); ex_nullified = 1; step();
      ex_op(1, 1, 0, 16'h0005); ex_stall = 1;     step();
      ex_op(1, 1, 0, 16'h0005); ex_flush = 1;     step();
      chk("blocked_flags", 32'({a_cq, a_zq, b_cq, b_zq}), 32'(4'hF));
      ex_op(1, 1, 0, 16'h0005); step();
      chk("write_clear", 32'({a_cq, a_zq, b_cq, b_zq}), 32'(0));

      // Load zero with EX idle: forwarded same cycle on fwd instance
      idle_inputs(); mem_valid = 1; mem_load_z = 1; mem_rdata = '0;
      #1;
      chk("load_fwd_zero", 32'(a_zero), 32'(1));
      #0 step();
      chk("load_zero_q", 32'({a_zq, b_zq}), 32'(2'b11));

      // Clear Z, then load-to-Z dependency from an R-type on-Z instruction
      ex_op(0, 1, 0, 16'h0003); step();
      idle_inputs(); ex_valid = 1; ex_rtype = 1; ex_z_in = 1;
      mem_valid = 1; mem_load_z = 1; mem_rdata = '0;
      #1;
      chk("ilk_stall_on", 32'(b_stall), 32'(1));
      #0 step();
      mem_valid = 0; mem_load_z = 0;
      #1;
      chk("ilk_stall_off", 32'(b_stall), 32'(0));
      chk("ilk_new_zero",  32'(b_zero),  32'(1));
      #0 step();

      // Same-edge EX and MEM Z writes: EX result wins
      ex_op(0, 1, 0, 16'h0005); mem_valid = 1; mem_load_z = 1; mem_rdata = '0;
      step();
      chk("collision_z", 32'({a_zq, b_zq}), 32'(0));

      // Nullified run: narrow counter saturates, wide one keeps counting
      for (int i = 0; i < 20; i++) begin
         ex_op(1, 1, 1, 16'h0000); ex_nullified = 1;
         ex_stall = (i % 7 == 3); ex_flush = (i % 9 == 5);
         step();
      end
      chk("sat_hold", 32'(a_cnt), 32'({CWA{1'b1}}));

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         ex_valid = 1'($urandom); ex_stall = ($urandom_range(0, 3) == 0);
         ex_flush = ($urandom_range(0, 5) == 0); ex_nullified = ($urandom_range(0, 3) == 0);
         ex_wr_c = 1'($urandom); ex_wr_z = 1'($urandom); ex_rtype = 1'($urandom);
         ex_c_in = 1'($urandom); ex_z_in = 1'($urandom); alu_carry = 1'($urandom);
         alu_result = 1'($urandom) ? '0 : W'($urandom);
         mem_valid = 1'($urandom); mem_load_z = 1'($urandom);
         mem_rdata = 1'($urandom) ? '0 : W'($urandom);
         step();
      end

      // Mid-run async reset with flags set and counters nonzero
      ex_op(1, 1, 1, 16'h0000); step();
      idle_inputs();
      #3;
      rst_n = 0;
      #1;
      model_reset();
      chk("mid_rst_q",    32'({a_cq, a_zq, b_cq, b_zq}), 32'(0));
      chk("mid_rst_fwd",  32'({a_carry, a_zero, b_carry, b_zero}), 32'(0));
      chk("mid_rst_cnt",  32'({a_cnt, b_cnt}), 32'(0));
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      ex_op(1, 0, 1, 16'h0001); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
